// File: rtl/movegen_pkg.sv
// movegen_pkg: shared constants, sequencer state type and square-index helper
//   NSQ         number of board squares
//   SQ_W        square-index width
//   CNT_W       move-counter width
//   seq_state_t sequencer states
//   sq_idx()    (rank, file) -> linear square index, a1=0 .. h8=63
package movegen_pkg;
    localparam int NSQ = 64;
    localparam int SQ_W = 6;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {IDLE, ATTACK, EMIT, DRAIN, DONE} seq_state_t;

    function automatic logic [SQ_W-1:0] sq_idx(input int rank, input int file);
        return SQ_W'((rank - 1) * 8 + (file - 1));
    endfunction
endpackage

// File: rtl/movegen_lsb64.sv
// movegen_lsb64: combinational lowest-set-bit encoder over a 64-bit square vector
//   vec  in   NSQ   square flags
//   idx  out  SQ_W  index of the lowest set bit (0 when vec is empty)
//   any  out  1     vec has at least one bit set
module movegen_lsb64
    import movegen_pkg::*;
(
    input  logic [NSQ-1:0]  vec,
    output logic [SQ_W-1:0] idx,
    output logic            any
);
    // Descending scan so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = NSQ - 1; i >= 0; i--) idx = vec[i] ? SQ_W'(i) : idx;
    end

    assign any = |vec;
endmodule

// File: rtl/movegen_sequencer.sv
// movegen_sequencer: drives one move-generation pass and serialises target masks into (from, to) records
//   clk, rst_n        clock, asynchronous active-low reset
//   start, wtp_in     begin a pass (IDLE only), side to play sampled with start
//   wtp               latched side to play
//   load_attackers    one-cycle attacker-load strobe
//   emit_move         one-hot source-square strobe
//   target_square     target flags returned by the array for the strobed source
//   mv_valid/ready    record handshake, mv_from/mv_to carry the record
//   busy, done        pass in progress, end-of-pass pulse
//   mv_count          saturating count of records accepted this pass
module movegen_sequencer #(
    parameter int NSQ   = 64,
    parameter int SQ_W  = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             wtp_in,
    output logic             wtp,
    output logic             load_attackers,
    output logic [NSQ-1:0]   emit_move,
    input  logic [NSQ-1:0]   target_square,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic [SQ_W-1:0]  mv_from,
    output logic [SQ_W-1:0]  mv_to,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mv_count
);
    import movegen_pkg::*;

    seq_state_t      state;
    logic [SQ_W-1:0] src;
    logic [SQ_W-1:0] lsb_idx;
    logic [NSQ-1:0]  mask;
    logic [NSQ-1:0]  mask_next;
    logic [NSQ-1:0]  next_onehot;
    logic            lsb_any;
    logic            last_src;

    movegen_lsb64 u_lsb (
        .vec (mask),
        .idx (lsb_idx),
        .any (lsb_any)
    );

    // Clearing the lowest set bit is the same as dropping the record just accepted.
    assign mask_next   = mask & (mask - 1'b1);
    assign next_onehot = NSQ'(1) << (src + 1'b1);
    assign last_src    = src == SQ_W'(NSQ - 1);

    assign mv_valid = (state == DRAIN) & lsb_any;
    assign mv_from  = mv_valid ? src : '0;
    assign mv_to    = mv_valid ? lsb_idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            src            <= '0;
            mask           <= '0;
            wtp            <= 1'b0;
            mv_count       <= '0;
            load_attackers <= 1'b0;
            emit_move      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            load_attackers <= 1'b0;
            emit_move      <= '0;
            done           <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state          <= ATTACK;
                    wtp            <= wtp_in;
                    mv_count       <= '0;
                    src            <= '0;
                    load_attackers <= 1'b1;
                    busy           <= 1'b1;
                end
                ATTACK: begin
                    state     <= EMIT;
                    emit_move <= NSQ'(1);
                end
                EMIT: begin
                    mask <= target_square;
                    if (|target_square) begin
                        state <= DRAIN;
                    end else if (last_src) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        src       <= src + 1'b1;
                        emit_move <= next_onehot;
                    end
                end
                DRAIN: if (mv_ready) begin
                    mask     <= mask_next;
                    mv_count <= (&mv_count) ? mv_count : mv_count + 1'b1;
                    // Final record of this source: move on with no idle cycle.
                    if (mask_next == '0 && last_src) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (mask_next == '0) begin
                        state     <= EMIT;
                        src       <= src + 1'b1;
                        emit_move <= next_onehot;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
